// File: rtl/dcache_controller.sv
// Blocking data-cache controller: hits complete in the cycle they are
// presented; a miss optionally writes back the dirty victim, fills the line
// from memory and then replays the held request as a hit.

// One word slot of a cache line: keeps the stored word or takes the store data.
module dcache_word_merge #(
    parameter int WORD_W = 32
) (
    input  logic              sel,
    input  logic [WORD_W-1:0] old_word,
    input  logic [WORD_W-1:0] new_word,
    output logic [WORD_W-1:0] merged
);
    assign merged = sel ? new_word : old_word;
endmodule

module dcache_controller #(
    parameter int TAG_W = 23,
    parameter int IDX_W = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    // CPU side
    input  logic                   cpu_req_i,
    input  logic                   cpu_wr_i,
    input  logic [31:0]            cpu_addr_i,
    input  logic [31:0]            cpu_data_i,
    output logic [31:0]            cpu_data_o,
    output logic                   cpu_stall_o,
    // tag/data SRAM side
    output logic [IDX_W-1:0]       sram_addr_o,
    output logic [TAG_W+1:0]       sram_tag_o,
    output logic [255:0]           sram_data_o,
    output logic                   sram_enable_o,
    output logic                   sram_write_o,
    input  logic [TAG_W+1:0]       sram_tag_i,
    input  logic [255:0]           sram_data_i,
    input  logic                   sram_hit_i,
    // memory side
    output logic                   mem_enable_o,
    output logic                   mem_write_o,
    output logic [31:0]            mem_addr_o,
    output logic [255:0]           mem_data_o,
    input  logic [255:0]           mem_data_i,
    input  logic                   mem_ack_i
);
    localparam int NUM_WORDS = 8;
    localparam int WORD_W    = 32;
    localparam int LINE_W    = NUM_WORDS * WORD_W;
    localparam int OFF_W     = 5;

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        READMISS,
        READMISSOK
    } state_t;

    // Outstanding memory request, held stable for the whole transaction.
    typedef struct packed {
        logic              en;
        logic              wr;
        logic [31:0]       addr;
        logic [LINE_W-1:0] data;
    } mem_req_t;

    state_t   state;
    mem_req_t mreq;
    logic     wb_first;

    logic [TAG_W-1:0]                  req_tag;
    logic [IDX_W-1:0]                  req_idx;
    logic [2:0]                        word_sel;
    logic [NUM_WORDS-1:0]              word_dec;
    logic [31:0]                       fill_addr;
    logic [31:0]                       victim_addr;
    logic                              victim_dirty;
    logic [NUM_WORDS-1:0][WORD_W-1:0]  line_in;
    logic [NUM_WORDS-1:0][WORD_W-1:0]  line_merged;
    logic                              unused_addr_bits;

    assign req_tag          = cpu_addr_i[31 -: TAG_W];
    assign req_idx          = cpu_addr_i[OFF_W +: IDX_W];
    assign word_sel         = cpu_addr_i[4:2];
    assign word_dec         = {{(NUM_WORDS-1){1'b0}}, 1'b1} << word_sel;
    assign fill_addr        = {cpu_addr_i[31:OFF_W], {OFF_W{1'b0}}};
    assign victim_addr      = {sram_tag_i[TAG_W-1:0], req_idx, {OFF_W{1'b0}}};
    assign victim_dirty     = sram_tag_i[TAG_W+1] & sram_tag_i[TAG_W];
    assign line_in          = sram_data_i;
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    // Store merge: one slot per word, only the addressed slot takes cpu_data_i.
    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_merge
        dcache_word_merge #(.WORD_W(WORD_W)) u_merge (
            .sel      (word_dec[g]),
            .old_word (line_in[g]),
            .new_word (cpu_data_i),
            .merged   (line_merged[g])
        );
    end

    // The SRAM is addressed straight from the CPU in every state.
    assign sram_addr_o   = req_idx;
    assign sram_enable_o = cpu_req_i;
    assign cpu_data_o    = line_in[word_sel];

    assign mem_enable_o  = mreq.en;
    assign mem_write_o   = mreq.wr;
    assign mem_addr_o    = mreq.addr;
    assign mem_data_o    = mreq.data;

    // Same-cycle hit path, fill write and stall; all quiet while in reset.
    always_comb begin
        sram_write_o = 1'b0;
        sram_data_o  = line_merged;
        sram_tag_o   = {1'b1, 1'b1, req_tag};
        cpu_stall_o  = 1'b1;
        case (state)
            IDLE: begin
                sram_write_o = cpu_req_i & sram_hit_i & cpu_wr_i;
                cpu_stall_o  = cpu_req_i & ~sram_hit_i;
            end
            READMISS: begin
                sram_write_o = mem_ack_i;
                sram_data_o  = mem_data_i;
                sram_tag_o   = {1'b1, 1'b0, req_tag};
            end
            default: ;
        endcase
        if (!rst_i) begin
            sram_write_o = 1'b0;
            cpu_stall_o  = 1'b0;
        end
    end

    // Miss sequencing and registered memory request; the first writeback
    // cycle ignores ack so a late ack from a dropped request cannot end it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            mreq     <= '0;
            wb_first <= 1'b0;
        end else begin
            wb_first <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req_i && !sram_hit_i) state <= MISS;
                end
                MISS: begin
                    mreq.en <= 1'b1;
                    if (victim_dirty) begin
                        state     <= WRITEBACK;
                        wb_first  <= 1'b1;
                        mreq.wr   <= 1'b1;
                        mreq.addr <= victim_addr;
                        mreq.data <= sram_data_i;
                    end else begin
                        state     <= READMISS;
                        mreq.wr   <= 1'b0;
                        mreq.addr <= fill_addr;
                    end
                end
                WRITEBACK: begin
                    if (!wb_first && mem_ack_i) begin
                        state     <= READMISS;
                        mreq.wr   <= 1'b0;
                        mreq.addr <= fill_addr;
                    end
                end
                READMISS: begin
                    if (mem_ack_i) begin
                        state   <= READMISSOK;
                        mreq.en <= 1'b0;
                    end
                end
                READMISSOK: state <= IDLE;
                default:    state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: SRAM and memory environment models plus a
// golden word memory and tag model that predict every hit, miss, writeback,
// fill, stall count and load value.
module tb_dcache_controller;
    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req, cpu_wr;
    logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
    logic         cpu_stall;
    logic [3:0]   sram_addr;
    logic [24:0]  sram_tag_w, sram_tag_r;
    logic [255:0] sram_data_w, sram_data_r;
    logic         sram_en, sram_we, sram_hit;
    logic         mem_en, mem_we, mem_ack;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dcache_controller dut (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(cpu_req), .cpu_wr_i(cpu_wr), .cpu_addr_i(cpu_addr),
        .cpu_data_i(cpu_wdata), .cpu_data_o(cpu_rdata), .cpu_stall_o(cpu_stall),
        .sram_addr_o(sram_addr), .sram_tag_o(sram_tag_w), .sram_data_o(sram_data_w),
        .sram_enable_o(sram_en), .sram_write_o(sram_we),
        .sram_tag_i(sram_tag_r), .sram_data_i(sram_data_r), .sram_hit_i(sram_hit),
        .mem_enable_o(mem_en), .mem_write_o(mem_we), .mem_addr_o(mem_addr),
        .mem_data_o(mem_wdata), .mem_data_i(mem_rdata), .mem_ack_i(mem_ack)
    );

    // SRAM environment: one entry per set, preload port for the bench.
    logic [24:0]  s_tag  [16];
    logic [255:0] s_line [16];
    logic         pl_en = 1'b0;
    logic [3:0]   pl_idx;
    logic [24:0]  pl_tag;
    logic [255:0] pl_line;

    assign sram_tag_r  = s_tag[sram_addr];
    assign sram_data_r = s_line[sram_addr];
    assign sram_hit    = s_tag[sram_addr][24] && (s_tag[sram_addr][22:0] == cpu_addr[31:9]);

    always @(posedge clk) begin
        if (pl_en) begin
            s_tag[pl_idx]  <= pl_tag;
            s_line[pl_idx] <= pl_line;
        end else if (sram_we) begin
            s_tag[sram_addr]  <= sram_tag_w;
            s_line[sram_addr] <= sram_data_w;
        end
    end

    // Reference: what every word should read as, what memory holds, and
    // which line each set holds.
    logic [31:0] gold [int unsigned];
    logic [31:0] bmem [int unsigned];
    bit          ref_valid [16];
    bit          ref_dirty [16];
    logic [22:0] ref_tag   [16];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B9) ^ 32'h5A5AA5A5;
    endfunction

    function automatic logic [31:0] gold_rd(input logic [31:0] a);
        if (gold.exists(a)) return gold[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] bmem_rd(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return init_word(a);
    endfunction

    function automatic logic [255:0] gold_line(input logic [31:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = gold_rd(la + 32'(4*i));
        return l;
    endfunction

    function automatic logic [255:0] bmem_line(input logic [31:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = bmem_rd(la + 32'(4*i));
        return l;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int ix, input logic [22:0] tg, input bit v, input bit d,
                           input logic [255:0] line);
        logic [31:0] la;
        @(negedge clk);
        pl_en = 1'b1; pl_idx = ix[3:0]; pl_tag = {v, d, tg}; pl_line = line;
        @(negedge clk);
        pl_en = 1'b0;
        ref_valid[ix] = v; ref_dirty[ix] = d; ref_tag[ix] = tg;
        la = {tg, ix[3:0], 5'b0};
        if (v) begin
            for (int i = 0; i < 8; i++) begin
                gold[la + 32'(4*i)] = line[32*i +: 32];
                if (!d) bmem[la + 32'(4*i)] = line[32*i +: 32];
            end
        end
    endtask

    // One CPU access with the bench acting as memory. Acks come on the
    // n-th cycle that mem_enable_o is high for that request; spur adds an
    // extra ack on the first writeback cycle; drop releases cpu_req once the
    // fill is under way.
    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int n_wb, input int n_fill, input bit spur, input bit drop);
        logic [22:0]  tg;
        logic [3:0]   ix;
        logic [31:0]  la, va, wa;
        logic [255:0] exp_line;
        logic [32:0]  key, pkey;
        bit           exp_hit, exp_wb, done, pen, ack, fill_seen;
        int           stalls, en_cnt, post, exp_stalls;
        tg = addr[31:9]; ix = addr[8:5];
        la = {addr[31:5], 5'b0}; wa = {addr[31:2], 2'b0};
        exp_hit = ref_valid[ix] && (ref_tag[ix] == tg);
        exp_wb  = !exp_hit && ref_valid[ix] && ref_dirty[ix];
        va = {ref_tag[ix], ix, 5'b0};
        exp_stalls = exp_hit ? 0 : 3 + n_fill + (exp_wb ? n_wb : 0);
        stalls = 0; en_cnt = 0; post = 0; done = 0; pen = 0; pkey = '0; fill_seen = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
        for (int c = 0; c < 200 && !done; c++) begin
            key = {mem_we, mem_addr};
            if (mem_en) en_cnt = (!pen || key != pkey) ? 1 : en_cnt + 1;
            else        en_cnt = 0;
            pen = mem_en; pkey = key;
            ack = 1'b0;
            if (mem_en && mem_we)  ack = (en_cnt == n_wb) || (spur && en_cnt == 1);
            if (mem_en && !mem_we) ack = (en_cnt == n_fill);
            mem_ack = ack;
            mem_rdata = bmem_line(mem_addr);
            if (drop && mem_en && !mem_we && en_cnt == 1) cpu_req = 1'b0;
            #1;
            if (ack && mem_we && en_cnt == n_wb) begin
                chk("wb_addr", mem_addr, va);
                chk("wb_data", mem_wdata, gold_line(va));
                for (int i = 0; i < 8; i++) bmem[mem_addr + 32'(4*i)] = mem_wdata[32*i +: 32];
            end
            if (ack && !mem_we) begin
                chk("fill_addr", mem_addr, la);
                chk("fill_we", sram_we, 1);
                chk("fill_tag", sram_tag_w, {2'b10, tg});
                chk("fill_data", sram_data_w, bmem_line(la));
                fill_seen = 1;
            end
            if (drop) begin
                if (fill_seen) post++;
                if (post == 3) done = 1;
            end else if (cpu_stall) begin
                stalls++;
            end else begin
                chk("stalls", 32'(stalls), 32'(exp_stalls));
                chk("sram_idx", sram_addr, ix);
                chk("sram_en", sram_en, 1);
                chk("no_mem_req", mem_en, 0);
                if (wr) begin
                    exp_line = gold_line(la);
                    exp_line[32*addr[4:2] +: 32] = wdata;
                    chk("st_we", sram_we, 1);
                    chk("st_tag", sram_tag_w, {2'b11, tg});
                    chk("st_data", sram_data_w, exp_line);
                end else begin
                    chk("ld_we", sram_we, 0);
                    chk("ld_data", cpu_rdata, gold_rd(wa));
                end
                done = 1;
            end
            @(negedge clk);
        end
        chk("timeout", done, 1);
        mem_ack = 1'b0; cpu_req = 1'b0; cpu_wr = 1'b0;
        if (!exp_hit) begin
            ref_valid[ix] = 1; ref_dirty[ix] = 0; ref_tag[ix] = tg;
        end
        if (wr && !drop) begin
            gold[wa] = wdata;
            ref_dirty[ix] = 1;
        end
    endtask

    initial begin
        logic [255:0] line;
        logic [31:0]  a;
        rst = 1'b0; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 16; i++) preload(i, '0, 0, 0, '0);

        // Reset state, with a missing request held to show stall stays low.
        cpu_req = 1'b1; cpu_addr = 32'h0000_ABE0;
        #1;
        chk("rst_stall", cpu_stall, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_wdata, 0);
        chk("rst_sram_we", sram_we, 0);
        @(negedge clk);
        cpu_req = 1'b0;
        rst = 1'b1;

        // Set 9 holds a clean line with word 1 = 0xDEADBEEF.
        line = gold_line(32'h0000_0120);
        line[63:32] = 32'hDEADBEEF;
        preload(9, '0, 1, 0, line);

        // Idle without request never writes; ack while idle is ignored.
        @(negedge clk);
        cpu_wr = 1'b1; cpu_addr = 32'h0000_0124; mem_ack = 1'b1;
        #1;
        chk("idle_no_write", sram_we, 0);
        chk("idle_ack_stall", cpu_stall, 0);
        @(negedge clk);
        mem_ack = 1'b0; cpu_wr = 1'b0;
        chk("idle_ack_mem_en", mem_en, 0);

        access(0, 32'h0000_0124, '0, 2, 1, 0, 0);             // load hit
        access(1, 32'h0000_0128, 32'h12345678, 2, 1, 0, 0);   // store hit
        access(0, 32'h0000_0128, '0, 2, 1, 0, 0);             // read it back
        access(0, 32'h0000_2040, '0, 2, 4, 0, 0);             // clean miss, 7 stalls
        access(0, 32'h0000_2044, '0, 2, 1, 0, 0);             // now a hit

        // Dirty victim, tag 7 in set 2; ack in the first writeback cycle is ignored.
        for (int i = 0; i < 8; i++) line[32*i +: 32] = $urandom;
        preload(2, 23'h7, 1, 1, line);
        access(0, 32'h0000_4040, '0, 3, 2, 1, 0);
        access(1, 32'h0000_4048, 32'hCAFEF00D, 2, 1, 0, 0);

        // Request dropped during the fill: the line still arrives.
        access(0, 32'h0000_67C0, '0, 2, 3, 0, 1);
        access(0, 32'h0000_67C4, '0, 2, 1, 0, 0);

        // Reset in the middle of a fill.
        @(negedge clk);
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h0000_ABE0;
        repeat (2) @(negedge clk);
        chk("rm_pending", mem_en, 1);
        rst = 1'b0;
        #1;
        chk("rm_rst_mem_en", mem_en, 0);
        chk("rm_rst_stall", cpu_stall, 0);
        chk("rm_rst_sram_we", sram_we, 0);
        @(negedge clk);
        rst = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = '1;
        #1;
        chk("late_ack_no_write", sram_we, 0);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack_mem_en", mem_en, 0);
        access(0, 32'h0000_ABE0, '0, 2, 2, 0, 0);

        // Random traffic over a few tags to mix hits, clean and dirty misses.
        for (int n = 0; n < 80; n++) begin
            a = {23'($urandom_range(3, 0)), 4'($urandom_range(15, 0)),
                 3'($urandom_range(7, 0)), 2'($urandom_range(3, 0))};
            access(1'($urandom_range(1, 0)), a, $urandom,
                   $urandom_range(4, 2), $urandom_range(4, 1), 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 The block SHALL have parameter TAG_W, default 23, meaning the address tag width, address bits [31:9].
REQ-002 The block SHALL have parameter IDX_W, default 4, meaning the set index width, address bits [8:5].
REQ-003 Port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port rst_i  input  1  reset, asynchronous and active-low.
REQ-005 Port cpu_req_i  input  1  CPU access request.
REQ-006 Port cpu_wr_i  input  1  CPU access is a store (1) or a load (0).
REQ-007 Port cpu_addr_i  input  32  CPU byte address; bits [4:2] select the word and bits [1:0] are ignored.
REQ-008 Port cpu_data_i  input  32  CPU store data.
REQ-009 Port cpu_data_o  output  32  load data.
REQ-010 Port cpu_stall_o  output  1  CPU must hold its request stable.
REQ-011 Port sram_addr_o  output  4  set index driven to the SRAM.
REQ-012 Port sram_tag_o  output  25  tag entry: [24] valid, [23] dirty, [22:0] tag.
REQ-013 Port sram_data_o  output  256  line write data.
REQ-014 Port sram_enable_o  output  1  SRAM access enable.
REQ-015 Port sram_write_o  output  1  SRAM write enable.
REQ-016 Port sram_tag_i  input  25  hit entry on a hit, otherwise the LRU victim entry.
REQ-017 Port sram_data_i  input  256  hit line on a hit, otherwise the LRU victim line.
REQ-018 Port sram_hit_i  input  1  combinational hit from the SRAM.
REQ-019 Port mem_enable_o  output  1  memory request.
REQ-020 Port mem_write_o  output  1  memory request is a writeback.
REQ-021 Port mem_addr_o  output  32  line-aligned memory address; bits [4:0] are 0.
REQ-022 Port mem_data_o  output  256  writeback line.
REQ-023 Port mem_data_i  input  256  fill line.
REQ-024 Port mem_ack_i  input  1  single-cycle completion pulse from memory.

Function
REQ-025 The block SHALL drive sram_addr_o = cpu_addr_i[8:5] and sram_enable_o = cpu_req_i in every state.
REQ-026 The block SHALL implement FSM states IDLE, MISS, WRITEBACK, READMISS and READMISSOK.
REQ-027 IDLE with a hit SHALL complete the access in the same cycle with cpu_stall_o = 0 and no state change.
REQ-028 A load hit SHALL return cpu_data_o = sram_data_i[32*w +: 32], where w = cpu_addr_i[4:2].
REQ-029 A store hit SHALL assert sram_write_o and set sram_data_o to sram_data_i with word w replaced by cpu_data_i.
REQ-030 A store hit SHALL set sram_tag_o = {1, 1, cpu_addr_i[31:9]}.
REQ-031 In IDLE, cpu_req_i with a miss SHALL assert cpu_stall_o combinationally and move to MISS.
REQ-032 cpu_stall_o SHALL stay high in MISS, WRITEBACK, READMISS and READMISSOK.
REQ-033 In MISS, a victim with sram_tag_i[24] and sram_tag_i[23] both set SHALL go to WRITEBACK.
REQ-034 On entering WRITEBACK the block SHALL latch mem_addr_o = {sram_tag_i[22:0], index, 5'b0} and mem_data_o = sram_data_i, and assert mem_write_o = 1.
REQ-035 In MISS, any other victim SHALL go to READMISS with mem_addr_o = {cpu_addr_i[31:5], 5'b0} and mem_write_o = 0.
REQ-036 mem_enable_o SHALL be high throughout WRITEBACK and READMISS and low in all other states.
REQ-037 mem_enable_o SHALL drop in the cycle after mem_ack_i is sampled.
REQ-038 In WRITEBACK, mem_ack_i SHALL move the FSM to READMISS with the fill address and mem_write_o = 0.
REQ-039 In WRITEBACK, the block SHALL ignore mem_ack_i during the first cycle of the state.
REQ-040 In READMISS, mem_ack_i SHALL write the line: sram_write_o = 1, sram_data_o = mem_data_i, sram_tag_o = {1, 0, cpu_addr_i[31:9]}.
REQ-041 In READMISS, mem_ack_i SHALL move the FSM to READMISSOK.
REQ-042 READMISSOK SHALL return to IDLE after one cycle; the held request then completes as a hit per REQ-027..030.
REQ-043 The miss penalty SHALL be 2 + ack latency without a writeback, plus the writeback ack latency when one occurs.
REQ-044 cpu_req_i deasserting in MISS, WRITEBACK or READMISS SHALL NOT abort the memory transaction; the line is still filled.
REQ-045 In IDLE, cpu_req_i = 0 SHALL hold sram_write_o = 0.
REQ-046 mem_ack_i asserted in IDLE or MISS SHALL be ignored.
REQ-047 Outside IDLE, cpu_data_o SHALL be don't-care.

Reset
REQ-048 On rst_i low the block SHALL asynchronously enter IDLE.
REQ-049 On reset the block SHALL clear mem_enable_o, mem_write_o, mem_addr_o, mem_data_o and sram_write_o to 0.
REQ-050 cpu_stall_o SHALL be 0 while rst_i is low.
REQ-051 Reset during an outstanding memory transaction SHALL drop it; a mem_ack_i arriving after release SHALL be ignored.

Verification
REQ-052 Load 0x0000_0124 to a valid line at set 9 with word 1 = 0xDEADBEEF -> cpu_data_o = 0xDEADBEEF, stall 0, no memory request.
REQ-053 Store 0x12345678 to addr 0x0000_0128 as a hit -> SRAM write of the merged line with tag {1, 1, 0x000000}, stall 0.
REQ-054 Clean miss on addr 0x0000_2040, ack after 5 cycles -> mem_addr_o = 0x0000_2040, mem_write_o = 0, stall high for 7 cycles, then a hit.
REQ-055 Dirty victim with tag 0x7 in set 2 on a miss to 0x0000_4040 -> writeback to 0x0000_0E40 with the victim line, then a fill from 0x0000_4040.
REQ-056 rst_i low mid-READMISS -> IDLE immediately, mem_enable_o = 0, and a later ack causes no SRAM write.
